// File: rtl/inst_rom_arb_pkg.sv
// Shared constants and small helpers for the instruction ROM arbiter.
// Constant values track INST_ROM_DEPTH / PORT_ADDR_WIDTH / PORT_DATA_WIDTH in define.v.
package inst_rom_arb_pkg;

    localparam int INST_ROM_DEPTH  = 512;
    localparam int PORT_ADDR_WIDTH = 32;
    localparam int PORT_DATA_WIDTH = 32;
    localparam int NUM_PORTS       = 2;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    function automatic port_e other_port(input port_e p);
        return (p == PORT_IF) ? PORT_LS : PORT_IF;
    endfunction

endpackage

// File: rtl/inst_rom_arb_if.sv
// Request/response channels of the fetch (if_*) and load/store (ls_*) ROM ports.
interface inst_rom_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid_i;
    logic              if_req_ready_o;
    logic [ADDR_W-1:0] if_req_addr_i;
    logic              if_flush_i;
    logic              if_resp_valid_o;
    logic              if_resp_ready_i;
    logic [DATA_W-1:0] if_resp_data_o;
    logic              if_resp_err_o;

    logic              ls_req_valid_i;
    logic              ls_req_ready_o;
    logic [ADDR_W-1:0] ls_req_addr_i;
    logic              ls_resp_valid_o;
    logic              ls_resp_ready_i;
    logic [DATA_W-1:0] ls_resp_data_o;
    logic              ls_resp_err_o;

    modport slave (
        input  if_req_valid_i, if_req_addr_i, if_flush_i, if_resp_ready_i,
        input  ls_req_valid_i, ls_req_addr_i, ls_resp_ready_i,
        output if_req_ready_o, if_resp_valid_o, if_resp_data_o, if_resp_err_o,
        output ls_req_ready_o, ls_resp_valid_o, ls_resp_data_o, ls_resp_err_o
    );

    modport master (
        output if_req_valid_i, if_req_addr_i, if_flush_i, if_resp_ready_i,
        output ls_req_valid_i, ls_req_addr_i, ls_resp_ready_i,
        input  if_req_ready_o, if_resp_valid_o, if_resp_data_o, if_resp_err_o,
        input  ls_req_ready_o, ls_resp_valid_o, ls_resp_data_o, ls_resp_err_o
    );
endinterface

// File: rtl/inst_rom_arb_slot.sv
// One-deep registered response slot with valid/ready, a load port and a clear input.
module inst_rom_arb_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              err_i,
    input  logic              resp_ready_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_data_o,
    output logic              resp_err_o
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    // Clear wins; a load in the draining cycle refills the slot back-to-back.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            err_d   = err_i;
        end else if (valid_q && resp_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid_o = valid_q;
    assign resp_data_o  = data_q;
    assign resp_err_o   = err_q;
endmodule

// File: rtl/inst_rom_arb.sv
// Round-robin arbiter sharing the combinational instruction ROM read port between
// the fetch unit (port 0) and the load/store unit (port 1), with registered responses.
module inst_rom_arb
    import inst_rom_arb_pkg::*;
#(
    parameter int ROM_DEPTH = INST_ROM_DEPTH,
    parameter int ADDR_W    = PORT_ADDR_WIDTH,
    parameter int DATA_W    = PORT_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    inst_rom_arb_if.slave     bus,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);
    logic [NUM_PORTS-1:0] req_valid, resp_ready, resp_valid, resp_err;
    logic [NUM_PORTS-1:0] clear, eligible, grant;
    logic [ADDR_W-1:0]    req_addr [NUM_PORTS];
    logic [DATA_W-1:0]    resp_data [NUM_PORTS];
    logic [ADDR_W-1:0]    word_idx;
    logic [DATA_W-1:0]    load_data;
    logic                 load_err;
    port_e                rr_q, rr_d;

    assign req_valid   = {bus.ls_req_valid_i, bus.if_req_valid_i};
    assign resp_ready  = {bus.ls_resp_ready_i, bus.if_resp_ready_i};
    assign req_addr[0] = bus.if_req_addr_i;
    assign req_addr[1] = bus.ls_req_addr_i;
    assign clear       = {1'b0, bus.if_flush_i};

    // A flushing fetch port is held off so the cleared slot is not refilled.
    assign eligible = req_valid & (~resp_valid | resp_ready) & ~clear;

    always_comb begin
        grant = eligible;
        rr_d  = rr_q;
        if (&eligible) begin
            grant = (rr_q == PORT_IF) ? 2'b01 : 2'b10;
            rr_d  = other_port(rr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= PORT_IF;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        rom_addr_o = '0;
        if (grant[0]) begin
            rom_addr_o = req_addr[0];
        end else if (grant[1]) begin
            rom_addr_o = req_addr[1];
        end
    end

    // Misaligned or beyond-the-end addresses return 0 with err instead of wrapping.
    assign word_idx  = rom_addr_o >> 2;
    assign load_err  = (rom_addr_o[1:0] != 2'b00) || (word_idx >= ADDR_W'(ROM_DEPTH));
    assign load_data = load_err ? '0 : rom_data_i;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
        inst_rom_arb_slot #(.DATA_W(DATA_W)) u_slot (
            .clk          (clk),
            .rst          (rst),
            .load_i       (grant[gi]),
            .clear_i      (clear[gi]),
            .data_i       (load_data),
            .err_i        (load_err),
            .resp_ready_i (resp_ready[gi]),
            .resp_valid_o (resp_valid[gi]),
            .resp_data_o  (resp_data[gi]),
            .resp_err_o   (resp_err[gi])
        );
    end

    assign bus.if_req_ready_o  = grant[0];
    assign bus.ls_req_ready_o  = grant[1];
    assign bus.if_resp_valid_o = resp_valid[0];
    assign bus.ls_resp_valid_o = resp_valid[1];
    assign bus.if_resp_data_o  = resp_data[0];
    assign bus.ls_resp_data_o  = resp_data[1];
    assign bus.if_resp_err_o   = resp_err[0];
    assign bus.ls_resp_err_o   = resp_err[1];
endmodule

// File: tb/tb_inst_rom_arb.sv
// Scoreboard bench for inst_rom_arb: grants push expected {err,data}, consumed responses pop.
module tb_inst_rom_arb;
    import inst_rom_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr, rom_data;
    logic [31:0] rom_mem [512];
    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb_q [2][$];
    logic [1:0]  gl = 2'b00;

    inst_rom_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_rom_arb dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data)
    );

    assign rom_data = rom_mem[rom_addr[10:2]];
    always #5 clk = ~clk;

    wire [1:0]  req_v  = {bus.ls_req_valid_i, bus.if_req_valid_i};
    wire [1:0]  req_r  = {bus.ls_req_ready_o, bus.if_req_ready_o};
    wire [1:0]  resp_v = {bus.ls_resp_valid_o, bus.if_resp_valid_o};
    wire [1:0]  resp_r = {bus.ls_resp_ready_i, bus.if_resp_ready_i};
    wire [32:0] if_pkt = {bus.if_resp_err_o, bus.if_resp_data_o};
    wire [32:0] ls_pkt = {bus.ls_resp_err_o, bus.ls_resp_data_o};

    function automatic logic [32:0] exp_of(input logic [31:0] a);
        logic e;
        e = (a[1:0] != 2'b00) || (a[31:2] >= 30'd512);
        return e ? {1'b1, 32'h0} : {1'b0, rom_mem[a[10:2]]};
    endfunction

    // One clock: scoreboard at the falling edge, then return just after the rising edge.
    task automatic cycle();
        logic [32:0] exp, act;
        logic [31:0] a;
        logic        g;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            act = (p == 0) ? if_pkt : ls_pkt;
            a   = (p == 0) ? bus.if_req_addr_i : bus.ls_req_addr_i;
            if (gl[p]) begin
                checks++;
                if (resp_v[p] !== 1'b1) begin
                    errors++;
                    $display("FAIL latency port%0d: resp_valid=%b required 1", p, resp_v[p]);
                end
            end
            if (resp_v[p] && resp_r[p]) begin
                checks++;
                if (sb_q[p].size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected port%0d: got %h with nothing expected", p, act);
                end else begin
                    exp = sb_q[p].pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL sb_data port%0d: got %h required %h", p, act, exp);
                    end
                end
            end
            g = req_v[p] & req_r[p];
            if (g) sb_q[p].push_back(exp_of(a));
            gl[p] = g;
        end
        if (bus.if_flush_i) sb_q[0].delete();
        if (rst) begin
            sb_q[0].delete();
            sb_q[1].delete();
            gl = 2'b00;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        #1;
        checks++;
        if ({resp_v, if_pkt, ls_pkt} !== 68'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b if=%h ls=%h required all 0", resp_v, if_pkt, ls_pkt);
        end
        $display("reset: valid=%b", resp_v);
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        bus.if_resp_ready_i = 1'b1;
        bus.if_req_valid_i  = 1'b1;
        bus.if_req_addr_i   = 32'h8;
        #1;
        checks++;
        if (bus.if_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b required 1", bus.if_req_ready_o);
        end
        cycle();
        bus.if_req_valid_i = 1'b0;
        #1;
        checks++;
        if ({bus.if_resp_valid_o, if_pkt} !== {1'b1, 1'b0, 32'h00500093}) begin
            errors++;
            $display("FAIL single_resp: valid=%b pkt=%h required 1 000500093", bus.if_resp_valid_o, if_pkt);
        end
        $display("single fetch: addr 0x8 data=%h err=%b", bus.if_resp_data_o, bus.if_resp_err_o);
        cycle();
    endtask

    task automatic test_contention();
        logic [31:0] ia, la;
        int          expp;
        do_reset();
        ia = 32'h0;
        la = 32'h100;
        bus.if_resp_ready_i = 1'b1;
        bus.ls_resp_ready_i = 1'b1;
        bus.if_req_valid_i  = 1'b1;
        bus.ls_req_valid_i  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.if_req_addr_i = ia;
            bus.ls_req_addr_i = la;
            #1;
            expp = i % 2;
            checks++;
            if (req_r !== ((expp == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL contention_grant cycle%0d: ready=%b required port%0d", i, req_r, expp);
            end
            $display("contention cycle %0d: ready=%b", i, req_r);
            cycle();
            if (expp == 0) ia += 32'd4; else la += 32'd4;
        end
        bus.if_req_valid_i = 1'b0;
        bus.ls_req_valid_i = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_backpressure();
        logic [32:0] held;
        logic [31:0] ia;
        do_reset();
        bus.if_resp_ready_i = 1'b1;
        bus.ls_resp_ready_i = 1'b0;
        bus.ls_req_valid_i  = 1'b1;
        bus.ls_req_addr_i   = 32'h200;
        #1;
        checks++;
        if (bus.ls_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_ready: got %b required 1", bus.ls_req_ready_o);
        end
        cycle();
        held = exp_of(32'h200);
        bus.ls_req_addr_i  = 32'h204;
        bus.if_req_valid_i = 1'b1;
        ia = 32'h40;
        for (int i = 0; i < 4; i++) begin
            bus.if_req_addr_i = ia;
            #1;
            checks++;
            if ({req_r, bus.ls_resp_valid_o, ls_pkt} !== {2'b01, 1'b1, held}) begin
                errors++;
                $display("FAIL bp_hold cycle%0d: ready=%b valid=%b pkt=%h required 01 1 %h",
                         i, req_r, bus.ls_resp_valid_o, ls_pkt, held);
            end
            $display("backpressure cycle %0d: ready=%b ls=%h", i, req_r, ls_pkt);
            cycle();
            ia += 32'd4;
        end
        bus.if_req_valid_i  = 1'b0;
        bus.ls_resp_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.ls_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b required 1", bus.ls_req_ready_o);
        end
        cycle();
        bus.ls_req_valid_i = 1'b0;
        #1;
        checks++;
        if ({bus.ls_resp_valid_o, ls_pkt} !== {1'b1, exp_of(32'h204)}) begin
            errors++;
            $display("FAIL bp_b2b: valid=%b pkt=%h required 1 %h", bus.ls_resp_valid_o, ls_pkt, exp_of(32'h204));
        end
        $display("backpressure release: ls=%h", ls_pkt);
        cycle();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [32:0] reqd  [3];
        addrs[0] = 32'h6;   reqd[0] = {1'b1, 32'h0};
        addrs[1] = 32'h800; reqd[1] = {1'b1, 32'h0};
        addrs[2] = 32'h7FC; reqd[2] = {1'b0, rom_mem[511]};
        bus.if_resp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.if_req_valid_i = 1'b1;
            bus.if_req_addr_i  = addrs[i];
            #1;
            checks++;
            if (bus.if_req_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL err_ready addr=%h: got %b required 1", addrs[i], bus.if_req_ready_o);
            end
            cycle();
            bus.if_req_valid_i = 1'b0;
            #1;
            checks++;
            if ({bus.if_resp_valid_o, if_pkt} !== {1'b1, reqd[i]}) begin
                errors++;
                $display("FAIL err_resp addr=%h: valid=%b pkt=%h required 1 %h",
                         addrs[i], bus.if_resp_valid_o, if_pkt, reqd[i]);
            end
            $display("errors: addr=%h err=%b data=%h", addrs[i], bus.if_resp_err_o, bus.if_resp_data_o);
            cycle();
        end
    endtask

    task automatic test_flush();
        bus.if_resp_ready_i = 1'b0;
        bus.if_req_valid_i  = 1'b1;
        bus.if_req_addr_i   = 32'h10;
        cycle();
        bus.if_flush_i    = 1'b1;
        bus.if_req_addr_i = 32'h14;
        #1;
        checks++;
        if (bus.if_req_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b required 0", bus.if_req_ready_o);
        end
        cycle();
        bus.if_flush_i = 1'b0;
        #1;
        checks++;
        if ({bus.if_resp_valid_o, bus.if_req_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL flush_clear: valid=%b ready=%b required 0 1", bus.if_resp_valid_o, bus.if_req_ready_o);
        end
        cycle();
        bus.if_req_valid_i  = 1'b0;
        bus.if_resp_ready_i = 1'b1;
        #1;
        checks++;
        if ({bus.if_resp_valid_o, if_pkt} !== {1'b1, exp_of(32'h14)}) begin
            errors++;
            $display("FAIL flush_refetch: valid=%b pkt=%h required 1 %h", bus.if_resp_valid_o, if_pkt, exp_of(32'h14));
        end
        $display("flush: refetch data=%h", bus.if_resp_data_o);
        cycle();
    endtask

    task automatic test_reset_mid_traffic();
        do_reset();
        bus.if_resp_ready_i = 1'b0;
        bus.ls_resp_ready_i = 1'b0;
        bus.if_req_valid_i  = 1'b1;
        bus.ls_req_valid_i  = 1'b1;
        bus.if_req_addr_i   = 32'h20;
        bus.ls_req_addr_i   = 32'h24;
        cycle();
        cycle();
        bus.if_req_valid_i = 1'b0;
        bus.ls_req_valid_i = 1'b0;
        #1;
        checks++;
        if (resp_v !== 2'b11) begin
            errors++;
            $display("FAIL mid_full: valid=%b required 11", resp_v);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.if_resp_ready_i = 1'b1;
        bus.ls_resp_ready_i = 1'b1;
        bus.if_req_valid_i  = 1'b1;
        bus.ls_req_valid_i  = 1'b1;
        #1;
        checks++;
        if ({resp_v, req_r} !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ready=%b required 00 01", resp_v, req_r);
        end
        $display("reset mid-traffic: valid=%b ready=%b", resp_v, req_r);
        cycle();
        #1;
        checks++;
        if (req_r !== 2'b10) begin
            errors++;
            $display("FAIL mid_second: ready=%b required 10", req_r);
        end
        cycle();
        bus.if_req_valid_i = 1'b0;
        bus.ls_req_valid_i = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) rom_mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0103);
        rom_mem[2] = 32'h0050_0093;
        bus.if_req_valid_i  = 1'b0;
        bus.if_req_addr_i   = 32'h0;
        bus.if_flush_i      = 1'b0;
        bus.if_resp_ready_i = 1'b0;
        bus.ls_req_valid_i  = 1'b0;
        bus.ls_req_addr_i   = 32'h0;
        bus.ls_resp_ready_i = 1'b0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_backpressure();
        test_errors();
        test_flush();
        test_reset_mid_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
